mux2_rr_arbiter: RTL
====================

Name: mux2_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 2:1 mux datapath between two packet requesters. It drives the mux select from its grant state and passes the granted requester's valid/ready handshake to a single downstream port. A grant is held for a whole packet, from the first beat through the beat flagged last.

Parameters:
DATA_W, 8, width of each requester data bus and of out_data
MAX_HOLD, 16, maximum grant duration in cycles (used only with MUX_ARB_TIMEOUT_EN)

Ports:
clk  input  1  single clock; all state changes on its rising edge
rst_n  input  1  asynchronous active-low reset
req  input  2  req[i] = requester i wants the datapath
in_valid  input  2  per-requester beat valid
in_last  input  2  per-requester last-beat flag, qualified by in_valid
in_data0  input  DATA_W  requester 0 data
in_data1  input  DATA_W  requester 1 data
in_ready  output  2  per-requester ready
gnt  output  2  one-hot registered grant, 00 when idle
sel  output  1  mux select: 0 = requester 0, 1 = requester 1
out_valid  output  1  downstream valid
out_last  output  1  downstream last
out_data  output  DATA_W  downstream data
out_ready  input  1  downstream ready
timeout_err  output  1  one-cycle pulse on forced release (feature only, else tied 0)

Behaviour:
- States: IDLE, GNT0, GNT1. gnt = 01 in GNT0, 10 in GNT1, 00 in IDLE. sel = 1 in GNT1, else 0. last_served is an internal 1-bit register.
- Reset (rst_n low, effective immediately): state IDLE, gnt 00, sel 0, last_served 1 so requester 0 wins first, timeout_err 0, hold counter 0. All outputs derived from state therefore read 0: out_valid, out_last, in_ready.
- IDLE, one request: go to the requesting side's GNT state.
- IDLE, both requesting: grant the requester that is not last_served.
- IDLE, no request: stay in IDLE.
- Arbitration latency from IDLE: 1 cycle. req sampled at edge N gives gnt valid after edge N.
- Datapath in GNTi is combinational, with zero latency:
  - out_data = in_data[sel], out_valid = in_valid[i], out_last = in_last[i].
  - in_ready[i] = out_ready; the ungranted requester's in_ready = 0.
  - Beat transfer = in_valid[i] & out_ready.
- Packet done in GNTi = a transfer with in_last[i] = 1. On done, last_served <= i, then:
  - other requester asserts req: switch directly to the other GNT state, with no idle bubble;
  - else req[i] still high: stay in GNTi;
  - else: go to IDLE.
- Abort: req[i] deasserts while in GNTi and in_valid[i] = 0. Go to IDLE and set last_served <= i.
- req[i] low with in_valid[i] high: the grant is kept.
- Once granted, the other requester's req is ignored until done or abort.
- gnt is always one-hot or zero. sel never changes in a cycle where out_valid & out_ready is asserted, except at the done edge.

Optional Feature:
MUX_ARB_TIMEOUT_EN
- Defined:
  - A hold counter clears on entry to any GNT state and increments every cycle in GNTi.
  - If it reaches MAX_HOLD-1 without done, the next edge forces release: the normal done transition applies with last_served <= i, and timeout_err pulses high for 1 cycle.
  - The counter resets on rst_n.
- Undefined: no counter exists, timeout_err is tied 0, and the grant is held indefinitely.

Test Plan:
- Reset with req=11 asserted, then release rst_n: gnt=01 one cycle after the first edge, sel=0, out_data=in_data0.
- Both requesting, each sending 2-beat packets (0xA1,0xA2 / 0xB1,0xB2), out_ready=1: downstream sequence A1,A2,B1,B2,A1,…; gnt alternates 01→10 with no idle cycle.
- Only req0, out_ready toggling 1,0,1: transfers occur only while out_ready=1; in_ready[1]=0 throughout; gnt stays 01.
- Assert rst_n low mid-packet in GNT1: gnt=00, out_valid=0, in_ready=00 before the next clk edge; the first grant after reset goes to requester 0.
- In GNT0, drop req0 with in_valid0=0: IDLE next cycle; a pending req1 is granted on the following cycle.
- With MUX_ARB_TIMEOUT_EN and MAX_HOLD=4, hold req0 high and in_last0=0, with req1 high: after 4 cycles timeout_err pulses once and gnt becomes 10.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one 2:1 mux datapath between two
// packet requesters. A grant is held from the first beat to the last beat.
// Optional build macro MUX_ARB_TIMEOUT_EN adds a hold counter that forces
// release after MAX_HOLD cycles and pulses timeout_err.
module mux2_rr_arbiter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        in_valid,
  input  logic [1:0]        in_last,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  output logic [1:0]        in_ready,
  output logic [1:0]        gnt,
  output logic              sel,
  output logic              out_valid,
  output logic              out_last,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              timeout_err
);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_served;
  logic   last_served_nxt;
  logic   granted;
  logic   cur;
  logic   xfer;
  logic   done;
  logic   abort;
  logic   force_rel;
  logic   rel;

  assign granted = (state != IDLE);
  assign cur     = (state == GNT1);
  assign xfer    = granted && in_valid[cur] && out_ready;
  assign done    = xfer && in_last[cur];
  assign abort   = granted && !req[cur] && !in_valid[cur];
  assign rel     = done || force_rel;

  // Grant and select come straight from the state flops.
  assign gnt = state;
  assign sel = state[1];

  // Zero-latency datapath steered by the current grant.
  always_comb begin
    out_data  = sel ? in_data1 : in_data0;
    out_valid = granted && in_valid[cur];
    out_last  = granted && in_valid[cur] && in_last[cur];
    in_ready  = 2'b00;
    if (state == GNT0) in_ready = {1'b0, out_ready};
    if (state == GNT1) in_ready = {out_ready, 1'b0};
  end

  // State and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_served <= 1'b1;
    end else begin
      state       <= state_nxt;
      last_served <= last_served_nxt;
    end
  end

  // Next-state: arbitrate in IDLE, hold grant until done, abort or forced release.
  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    case (state)
      IDLE: begin
        if (req[0] && req[1]) state_nxt = last_served ? GNT0 : GNT1;
        else if (req[0])      state_nxt = GNT0;
        else if (req[1])      state_nxt = GNT1;
      end
      default: begin
        if (rel) begin
          last_served_nxt = cur;
          if (req[!cur])     state_nxt = cur ? GNT0 : GNT1;
          else if (req[cur]) state_nxt = state;
          else               state_nxt = IDLE;
        end else if (abort) begin
          last_served_nxt = cur;
          state_nxt       = IDLE;
        end
      end
    endcase
  end

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HOLD_W-1:0] hold_cnt;
  logic              timeout_q;

  assign force_rel   = granted && !done && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign timeout_err = timeout_q;

  // Hold counter restarts on every new grant; timeout flag is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= force_rel;
      if ((state_nxt != state) || rel) hold_cnt <= '0;
      else if (granted)                hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end
`else
  logic unused_max_hold;

  assign force_rel       = 1'b0;
  assign timeout_err     = 1'b0;
  assign unused_max_hold = ^32'(MAX_HOLD);
`endif

endmodule
